dot_product_sequencer: RTL and testbench

- Upstream control stage for the matrix accelerator. It accepts a stream of (a, b) float element pairs and packs them into groups of up to IN_PORTS lanes.
- Per group it drives the multiplier lanes and start strobes, waits for all started multipliers to report ready, then strobes the matching output adders.
- On the last element of a vector it triggers the final accumulation, captures the scalar result into a valid/ready output register, and pulses an accumulator clear.

---
 rtl/dot_product_sequencer_if.sv | 44 ++++
 rtl/dot_product_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_dot_product_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dot_product_sequencer_if.sv
// Bundle of every handshake and data signal between the dot product
// sequencer and the rest of the matrix accelerator. Clock and reset stay
// outside the bundle.
// master : the sequencer itself
// slave  : the environment (element source, multipliers, adders, result sink)
interface dot_product_sequencer_if #(
    parameter int BIT_LEN   = 32,
    parameter int IN_PORTS  = 4,
    parameter int OUT_PORTS = 4,
    parameter int ADDR_LEN  = 4
);
    logic                          s_valid;
    logic                          s_ready;
    logic [BIT_LEN-1:0]            s_a;
    logic [BIT_LEN-1:0]            s_b;
    logic                          s_last;
    logic [IN_PORTS*BIT_LEN-1:0]   mult_a;
    logic [IN_PORTS*BIT_LEN-1:0]   mult_b;
    logic [IN_PORTS-1:0]           m_start;
    logic [IN_PORTS-1:0]           m_ready;
    logic                          direct;
    logic [ADDR_LEN-1:0]           addr_sel;
    logic [OUT_PORTS-1:0]          add;
    logic                          fin_add;
    logic                          fin_ready;
    logic [2*BIT_LEN-1:0]          fin_data;
    logic                          acc_clr;
    logic                          r_valid;
    logic                          r_ready;
    logic [2*BIT_LEN-1:0]          r_data;
    logic                          err;

    modport master (
        input  s_valid, s_a, s_b, s_last, m_ready, fin_ready, fin_data, r_ready,
        output s_ready, mult_a, mult_b, m_start, direct, addr_sel, add,
               fin_add, acc_clr, r_valid, r_data, err
    );

    modport slave (
        output s_valid, s_a, s_b, s_last, m_ready, fin_ready, fin_data, r_ready,
        input  s_ready, mult_a, mult_b, m_start, direct, addr_sel, add,
               fin_add, acc_clr, r_valid, r_data, err
    );
endinterface

// File: rtl/dot_product_sequencer.sv
// Upstream control stage for the matrix accelerator. Packs incoming (a, b)
// element pairs into groups of up to IN_PORTS multiplier lanes, starts the
// multipliers, waits for them, strobes the output adders and, at the end of
// a vector, runs the final accumulation and presents the scalar result.
// Optional watchdog: define SEQ_TIMEOUT_EN to enable the TIMEOUT counter and
// the sticky err flag; otherwise err is tied low and waits are unbounded.
module dot_product_sequencer #(
    parameter int BIT_LEN   = 32,
    parameter int IN_PORTS  = 4,
    parameter int OUT_PORTS = 4,
    parameter int ADDR_LEN  = 4,
    parameter int TIMEOUT   = 1024
) (
    input  logic                    Clk,
    input  logic                    Rst,
    dot_product_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        FILL, ISSUE, WAIT_M, ADD, FINAL, WAIT_F, OUT, CLR
    } state_t;

    localparam int CNT_W = $clog2(IN_PORTS + 1);

    // A lane count larger than the adder count, or a zero watchdog, cannot work
    if (IN_PORTS > OUT_PORTS || TIMEOUT < 1) begin : gBadConfig
        $error("dot_product_sequencer: need IN_PORTS <= OUT_PORTS and TIMEOUT >= 1");
    end

    state_t                      state_q;
    logic [CNT_W-1:0]            cnt_q;
    logic [IN_PORTS-1:0]         mask_q;
    logic [IN_PORTS-1:0]         mask_d;
    logic [IN_PORTS-1:0]         seen_q;
    logic [IN_PORTS-1:0]         seen_d;
    logic [IN_PORTS-1:0]         laneSel;
    logic [IN_PORTS-1:0]         mStart_q;
    logic [OUT_PORTS-1:0]        add_q;
    logic                        last_q;
    logic                        finPrev_q;
    logic                        sReady_q;
    logic                        finAdd_q;
    logic                        accClr_q;
    logic                        rValid_q;
    logic [2*BIT_LEN-1:0]        rData_q;
    logic [IN_PORTS*BIT_LEN-1:0] multA_q;
    logic [IN_PORTS*BIT_LEN-1:0] multB_q;
    logic                        beat;
    logic                        finEdge;

`ifdef SEQ_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    logic [TMR_W-1:0]            timer_q;
    logic                        drop_q;
    logic                        err_q;
    logic                        timeUp;
    assign timeUp = (timer_q == TMR_W'(TIMEOUT - 1));
`endif

    // One-hot select of the lane the next accepted beat lands in
    always_comb begin
        laneSel = '0;
        for (int n = 0; n < IN_PORTS; n++) begin
            if (cnt_q == CNT_W'(n)) laneSel[n] = 1'b1;
        end
    end

    assign mask_d  = mask_q | laneSel;
    assign seen_d  = seen_q | (bus.m_ready & mask_q);
    assign beat    = bus.s_valid & sReady_q;
    assign finEdge = bus.fin_ready & ~finPrev_q;

    // Sequencer FSM: all control outputs are registered and pulses self-clear
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= FILL;
            cnt_q     <= '0;
            mask_q    <= '0;
            seen_q    <= '0;
            last_q    <= 1'b0;
            finPrev_q <= 1'b0;
            sReady_q  <= 1'b1;
            mStart_q  <= '0;
            add_q     <= '0;
            finAdd_q  <= 1'b0;
            accClr_q  <= 1'b0;
            rValid_q  <= 1'b0;
            rData_q   <= '0;
            multA_q   <= '0;
            multB_q   <= '0;
`ifdef SEQ_TIMEOUT_EN
            timer_q   <= '0;
            drop_q    <= 1'b0;
            err_q     <= 1'b0;
`endif
        end else begin
            finPrev_q <= bus.fin_ready;
            mStart_q  <= '0;
            add_q     <= '0;
            finAdd_q  <= 1'b0;
            accClr_q  <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            timer_q   <= '0;
`endif
            case (state_q)
                FILL: begin
                    if (beat) begin
`ifdef SEQ_TIMEOUT_EN
                        if (drop_q) begin
                            if (bus.s_last) drop_q <= 1'b0;
                        end else
`endif
                        begin
                            for (int n = 0; n < IN_PORTS; n++) begin
                                if (laneSel[n]) begin
                                    multA_q[n*BIT_LEN +: BIT_LEN] <= bus.s_a;
                                    multB_q[n*BIT_LEN +: BIT_LEN] <= bus.s_b;
                                end
                            end
                            mask_q <= mask_d;
                            cnt_q  <= cnt_q + CNT_W'(1);
                            if (cnt_q == CNT_W'(IN_PORTS - 1) || bus.s_last) begin
                                state_q  <= ISSUE;
                                sReady_q <= 1'b0;
                                last_q   <= bus.s_last;
                                mStart_q <= mask_d;
                            end
                        end
                    end
                end
                ISSUE: state_q <= WAIT_M;
                WAIT_M: begin
                    seen_q <= seen_d;
                    if (seen_d == mask_q) begin
                        state_q <= ADD;
                        add_q   <= OUT_PORTS'(mask_q);
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (timeUp) begin
                        err_q    <= 1'b1;
                        drop_q   <= ~last_q;
                        mask_q   <= '0;
                        seen_q   <= '0;
                        cnt_q    <= '0;
                        accClr_q <= 1'b1;
                        state_q  <= CLR;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
`endif
                end
                ADD: begin
                    mask_q <= '0;
                    seen_q <= '0;
                    cnt_q  <= '0;
                    if (last_q) begin
                        state_q  <= FINAL;
                        finAdd_q <= 1'b1;
                    end else begin
                        state_q  <= FILL;
                        sReady_q <= 1'b1;
                    end
                end
                FINAL: state_q <= WAIT_F;
                WAIT_F: begin
                    if (finEdge) begin
                        rData_q  <= bus.fin_data;
                        rValid_q <= 1'b1;
                        state_q  <= OUT;
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (timeUp) begin
                        err_q    <= 1'b1;
                        accClr_q <= 1'b1;
                        state_q  <= CLR;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
`endif
                end
                OUT: begin
                    if (bus.r_ready) begin
                        rValid_q <= 1'b0;
                        accClr_q <= 1'b1;
                        state_q  <= CLR;
                    end
                end
                CLR: begin
                    last_q   <= 1'b0;
                    sReady_q <= 1'b1;
                    state_q  <= FILL;
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign bus.s_ready  = sReady_q;
    assign bus.mult_a   = multA_q;
    assign bus.mult_b   = multB_q;
    assign bus.m_start  = mStart_q;
    assign bus.direct   = 1'b1;
    assign bus.addr_sel = '0;
    assign bus.add      = add_q;
    assign bus.fin_add  = finAdd_q;
    assign bus.acc_clr  = accClr_q;
    assign bus.r_valid  = rValid_q;
    assign bus.r_data   = rData_q;
`ifdef SEQ_TIMEOUT_EN
    assign bus.err      = err_q;
`else
    assign bus.err      = 1'b0;
`endif
endmodule

// File: tb/tb_dot_product_sequencer.sv
// Self-checking bench for dot_product_sequencer. The bench plays the element
// source, the multiplier/adder stubs and the result consumer, and predicts
// lane grouping, masks and the returned scalar from the vector contents.
module tb_dot_product_sequencer;
    localparam int BIT_LEN   = 32;
    localparam int IN_PORTS  = 4;
    localparam int OUT_PORTS = 4;
    localparam int ADDR_LEN  = 4;
    localparam int TIMEOUT   = 16;

    logic Clk;
    logic Rst;
    int   compared;
    int   mismatched;
    logic expErr;
    logic [31:0] va[$];
    logic [31:0] vb[$];
    int   fixedDelay[4] = '{2, 4, 0, 4};

    dot_product_sequencer_if #(
        .BIT_LEN(BIT_LEN), .IN_PORTS(IN_PORTS),
        .OUT_PORTS(OUT_PORTS), .ADDR_LEN(ADDR_LEN)
    ) busIf ();

    dot_product_sequencer #(
        .BIT_LEN(BIT_LEN), .IN_PORTS(IN_PORTS), .OUT_PORTS(OUT_PORTS),
        .ADDR_LEN(ADDR_LEN), .TIMEOUT(TIMEOUT)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .bus(busIf)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic last);
        busIf.s_valid = 1'b1;
        busIf.s_a     = a;
        busIf.s_b     = b;
        busIf.s_last  = last;
    endtask

    task automatic waitSReady();
        int n = 0;
        while (busIf.s_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checkOutput("s_ready wait", busIf.s_ready, 1'b1);
    endtask

    task automatic fillRandom(input int len);
        va.delete();
        vb.delete();
        for (int i = 0; i < len; i++) begin
            va.push_back($urandom());
            vb.push_back($urandom());
        end
    endtask

    // Called in the ISSUE cycle of a group of n elements starting at index start
    task automatic processGroup(input int start, input int n, input bit isLast, input bit stagger);
        logic [3:0]   mask;
        logic [127:0] expA, expB, keep;
        logic [3:0]   rdy;
        int d[4];
        int maxD;
        mask = '0; expA = '0; expB = '0; keep = '0; maxD = 0;
        for (int k = 0; k < n; k++) begin
            mask[k] = 1'b1;
            expA[k*32 +: 32] = va[start+k];
            expB[k*32 +: 32] = vb[start+k];
            keep[k*32 +: 32] = 32'hFFFF_FFFF;
        end
        checkOutput("m_start", busIf.m_start, mask);
        checkOutput("s_ready issue", busIf.s_ready, 1'b0);
        checkOutput("mult_a", busIf.mult_a & keep, expA);
        checkOutput("mult_b", busIf.mult_b & keep, expB);
        tick();
        checkOutput("m_start pulse", busIf.m_start, 4'b0000);
        for (int k = 0; k < 4; k++) begin
            d[k] = stagger ? fixedDelay[k] : int'($urandom_range(0, 3));
            if (mask[k] && d[k] > maxD) maxD = d[k];
        end
        for (int t = 0; t <= maxD; t++) begin
            rdy = '0;
            for (int k = 0; k < 4; k++) begin
                if (mask[k]) rdy[k] = (d[k] == t);
                else         rdy[k] = 1'($urandom_range(0, 1));
            end
            busIf.m_ready = rdy;
            checkOutput("add early", busIf.add, 4'b0000);
            tick();
        end
        busIf.m_ready = '0;
        checkOutput("add", busIf.add, mask);
        checkOutput("mult_a hold", busIf.mult_a & keep, expA);
        tick();
        checkOutput("add pulse", busIf.add, 4'b0000);
        if (isLast) checkOutput("fin_add", busIf.fin_add, 1'b1);
        else        checkOutput("s_ready refill", busIf.s_ready, 1'b1);
    endtask

    // Called in the FINAL cycle; fin_ready is left high afterwards so the next
    // vector sees a stale high level on entry to its final wait
    task automatic finishVector(input logic [63:0] finData, input int rDelay);
        tick();
        checkOutput("fin_add pulse", busIf.fin_add, 1'b0);
        busIf.fin_data = finData;
        for (int k = 0; k < 2; k++) begin
            tick();
            checkOutput("r_valid stale fin_ready", busIf.r_valid, 1'b0);
        end
        busIf.fin_ready = 1'b0;
        tick();
        checkOutput("r_valid before edge", busIf.r_valid, 1'b0);
        busIf.fin_ready = 1'b1;
        tick();
        checkOutput("r_valid", busIf.r_valid, 1'b1);
        checkOutput("r_data", busIf.r_data, finData);
        busIf.fin_data = 64'($urandom());
        for (int k = 0; k < rDelay; k++) begin
            tick();
            checkOutput("r_valid hold", busIf.r_valid, 1'b1);
            checkOutput("r_data hold", busIf.r_data, finData);
            checkOutput("s_ready out", busIf.s_ready, 1'b0);
            checkOutput("acc_clr early", busIf.acc_clr, 1'b0);
        end
        busIf.r_ready = 1'b1;
        tick();
        busIf.r_ready = 1'b0;
        checkOutput("r_valid drop", busIf.r_valid, 1'b0);
        checkOutput("acc_clr", busIf.acc_clr, 1'b1);
        checkOutput("s_ready clr", busIf.s_ready, 1'b0);
        tick();
        checkOutput("acc_clr pulse", busIf.acc_clr, 1'b0);
        checkOutput("s_ready after clr", busIf.s_ready, 1'b1);
        checkOutput("err", busIf.err, expErr);
    endtask

    task automatic sendVector(input int len, input logic [63:0] finData,
                              input int rDelay, input bit stagger);
        int groupStart = 0;
        for (int i = 0; i < len; i++) begin
            applyStimulus(va[i], vb[i], i == len - 1);
            waitSReady();
            tick();
            if ((i - groupStart) == IN_PORTS - 1 || i == len - 1) begin
                if (i < len - 1) applyStimulus(va[i+1], vb[i+1], (i + 1) == len - 1);
                else busIf.s_valid = 1'b0;
                processGroup(groupStart, i - groupStart + 1, i == len - 1, stagger);
                groupStart = i + 1;
            end
        end
        finishVector(finData, rDelay);
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        expErr = 1'b0;
        Rst = 1'b1;
        busIf.s_valid = 1'b0;
        busIf.s_a = '0;
        busIf.s_b = '0;
        busIf.s_last = 1'b0;
        busIf.m_ready = '0;
        busIf.fin_ready = 1'b0;
        busIf.fin_data = '0;
        busIf.r_ready = 1'b0;
        tick();
        tick();
        $display("[TB] reset values");
        checkOutput("reset s_ready", busIf.s_ready, 1'b1);
        checkOutput("reset m_start", busIf.m_start, 4'b0000);
        checkOutput("reset add", busIf.add, 4'b0000);
        checkOutput("reset fin_add", busIf.fin_add, 1'b0);
        checkOutput("reset acc_clr", busIf.acc_clr, 1'b0);
        checkOutput("reset r_valid", busIf.r_valid, 1'b0);
        checkOutput("reset r_data", busIf.r_data, 64'h0);
        checkOutput("reset mult_a", busIf.mult_a, 128'h0);
        checkOutput("reset err", busIf.err, 1'b0);
        checkOutput("direct", busIf.direct, 1'b1);
        checkOutput("addr_sel", busIf.addr_sel, 4'h0);
        Rst = 1'b0;
        tick();

        $display("[TB] four element vector");
        va = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        vb = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
        sendVector(4, 64'h4024000000000000, 2, 1'b0);

        $display("[TB] six element vector");
        fillRandom(6);
        sendVector(6, {$urandom(), $urandom()}, int'($urandom_range(0, 3)), 1'b0);

        $display("[TB] single element vector");
        fillRandom(1);
        sendVector(1, {$urandom(), $urandom()}, 1, 1'b0);

        $display("[TB] staggered multiplier ready");
        fillRandom(4);
        sendVector(4, {$urandom(), $urandom()}, 0, 1'b1);

        $display("[TB] result consumer stalled");
        fillRandom(5);
        sendVector(5, {$urandom(), $urandom()}, 10, 1'b0);

        $display("[TB] reset during multiplier wait");
        fillRandom(4);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(va[i], vb[i], 1'b0);
            waitSReady();
            tick();
        end
        busIf.s_valid = 1'b0;
        checkOutput("m_start pre-reset", busIf.m_start, 4'b1111);
        tick();
        #2;
        Rst = 1'b1;
        #1;
        checkOutput("rst s_ready", busIf.s_ready, 1'b1);
        checkOutput("rst m_start", busIf.m_start, 4'b0000);
        checkOutput("rst mult_a", busIf.mult_a, 128'h0);
        checkOutput("rst mult_b", busIf.mult_b, 128'h0);
        checkOutput("rst r_data", busIf.r_data, 64'h0);
        checkOutput("rst r_valid", busIf.r_valid, 1'b0);
        checkOutput("rst add", busIf.add, 4'b0000);
        tick();
        Rst = 1'b0;
        tick();

        $display("[TB] eight element vector after reset");
        fillRandom(8);
        sendVector(8, {$urandom(), $urandom()}, 1, 1'b0);

`ifdef SEQ_TIMEOUT_EN
        $display("[TB] watchdog expiry");
        fillRandom(6);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(va[i], vb[i], 1'b0);
            waitSReady();
            tick();
        end
        busIf.s_valid = 1'b0;
        checkOutput("m_start timeout group", busIf.m_start, 4'b1111);
        tick();
        for (int k = 1; k < TIMEOUT; k++) begin
            tick();
            checkOutput("err before expiry", busIf.err, 1'b0);
        end
        tick();
        checkOutput("err expiry", busIf.err, 1'b1);
        checkOutput("acc_clr expiry", busIf.acc_clr, 1'b1);
        checkOutput("r_valid expiry", busIf.r_valid, 1'b0);
        tick();
        checkOutput("s_ready after expiry", busIf.s_ready, 1'b1);
        for (int i = 4; i < 6; i++) begin
            applyStimulus(va[i], vb[i], i == 5);
            waitSReady();
            tick();
            checkOutput("discard m_start", busIf.m_start, 4'b0000);
            checkOutput("discard r_valid", busIf.r_valid, 1'b0);
        end
        busIf.s_valid = 1'b0;
        tick();
        checkOutput("discard s_ready", busIf.s_ready, 1'b1);
        expErr = 1'b1;
        fillRandom(3);
        sendVector(3, {$urandom(), $urandom()}, 1, 1'b0);
`endif

        $display("[TB] random vectors");
        for (int r = 0; r < 6; r++) begin
            int len;
            len = int'($urandom_range(1, 9));
            fillRandom(len);
            sendVector(len, {$urandom(), $urandom()}, int'($urandom_range(0, 3)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
